tx_gearbox66: RTL and testbench

Transmit-side 66b→32b gearbox for the RD53B Aurora-style lane. It takes 64-bit payloads with a 2-bit sync header from the block framer and packs the resulting 66-bit blocks, header first, into a continuous stream of 32-bit words for the serializer. It is the transmit counterpart of the receive-side gearbox and header seeker: the words it emits must be re-alignable by that path.

---
 rtl/tx_gearbox66_pkg.sv | 24 ++
 rtl/tx_gearbox66_if.sv | 24 ++
 rtl/tx_gearbox66.sv | 99 +++++++++
 tb/tb_tx_gearbox66.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_gearbox66_pkg.sv
// rtl/tx_gearbox66_pkg.sv - shared 66b/32b gearbox constants and block type (tx/rx common)
package tx_gearbox66_pkg;

    localparam logic [1:0]  c_DATA_HEADER  = 2'b01;
    localparam logic [1:0]  c_CMD_HEADER   = 2'b10;
    localparam logic [63:0] c_IDLE_PAYLOAD = 64'h7800_0000_0000_0000;

    localparam int c_BLOCK_W     = 66;
    localparam int c_WORD_W      = 32;
    localparam int c_FRAME_WORDS = 33;

    typedef struct packed {
        logic [1:0]  hdr;
        logic [63:0] data;
    } block66_t;

    function automatic block66_t idle_block();
        block66_t b;
        b.hdr  = c_CMD_HEADER;
        b.data = c_IDLE_PAYLOAD;
        return b;
    endfunction

endpackage

// File: rtl/tx_gearbox66_if.sv
// rtl/tx_gearbox66_if.sv - block input handshake and word output bundle of the tx gearbox
interface tx_gearbox66_if;
    import tx_gearbox66_pkg::*;

    logic [63:0]         data_i;
    logic [1:0]          hdr_i;
    logic                valid_i;
    logic                ready_o;
    logic [c_WORD_W-1:0] gbox_data_o;
    logic                gbox_dv_o;
    logic [5:0]          gbox_cnt_o;
    logic                idle_ins_o;

    modport slave (
        input  data_i, hdr_i, valid_i,
        output ready_o, gbox_data_o, gbox_dv_o, gbox_cnt_o, idle_ins_o
    );

    modport master (
        output data_i, hdr_i, valid_i,
        input  ready_o, gbox_data_o, gbox_dv_o, gbox_cnt_o, idle_ins_o
    );

endinterface

// File: rtl/tx_gearbox66.sv
// rtl/tx_gearbox66.sv - 66b->32b transmit gearbox; optional idle insertion via TX_IDLE_INSERT_EN
module tx_gearbox66
    import tx_gearbox66_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    tx_gearbox66_if.slave bus
);

    localparam int         c_RES_W  = c_BLOCK_W - 1;
    localparam int         c_CAT_W  = c_RES_W + c_WORD_W;
    localparam logic [6:0] c_WORD_F = 7'(c_WORD_W);
    localparam logic [6:0] c_BLK_F  = 7'(c_BLOCK_W);

    logic [c_RES_W-1:0]  res_q, res_d;
    logic [6:0]          fill_q, fill_d;
    logic [c_WORD_W-1:0] data_q, data_d;
    logic                dv_q, dv_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [5:0]          widx_q, widx_d;
    logic                idle_q, idle_d;

    logic                ready;
    logic                accept;
    logic                idle_fill;
    logic                append;
    block66_t            blk;
    logic [c_CAT_W-1:0]  blk_ext;
    logic [c_CAT_W-1:0]  cat;
    logic [6:0]          total;

    assign ready  = !rst_i && (fill_q < c_WORD_F);
    assign accept = bus.valid_i && ready;

`ifdef TX_IDLE_INSERT_EN
    assign idle_fill = !bus.valid_i && (fill_q < c_WORD_F);
`else
    assign idle_fill = 1'b0;
`endif

    assign append = accept || idle_fill;
    assign blk    = accept ? block66_t'({bus.hdr_i, bus.data_i}) : idle_block();

    // New block lands directly below the fill_q residue bits; residue below fill_q is always zero.
    always_comb begin
        blk_ext = '0;
        if (append) begin
            blk_ext = {blk, {(c_WORD_W-1){1'b0}}} >> fill_q;
        end
        cat   = {res_q, {c_WORD_W{1'b0}}} | blk_ext;
        total = fill_q + (append ? c_BLK_F : 7'd0);
    end

    always_comb begin
        res_d  = cat[c_CAT_W-1 -: c_RES_W];
        fill_d = total;
        data_d = data_q;
        dv_d   = 1'b0;
        cnt_d  = cnt_q;
        widx_d = widx_q;
        idle_d = idle_fill;
        if (total >= c_WORD_F) begin
            data_d = cat[c_CAT_W-1 -: c_WORD_W];
            dv_d   = 1'b1;
            res_d  = cat[c_RES_W-1:0];
            fill_d = total - c_WORD_F;
            // cnt reports the frame index of the word being presented, so header words of block 16n read 0
            cnt_d  = widx_q;
            widx_d = (widx_q == 6'(c_FRAME_WORDS - 1)) ? 6'd0 : widx_q + 6'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            res_q  <= '0;
            fill_q <= '0;
            data_q <= '0;
            dv_q   <= 1'b0;
            cnt_q  <= '0;
            widx_q <= '0;
            idle_q <= 1'b0;
        end else begin
            res_q  <= res_d;
            fill_q <= fill_d;
            data_q <= data_d;
            dv_q   <= dv_d;
            cnt_q  <= cnt_d;
            widx_q <= widx_d;
            idle_q <= idle_d;
        end
    end

    assign bus.ready_o     = ready;
    assign bus.gbox_data_o = data_q;
    assign bus.gbox_dv_o   = dv_q;
    assign bus.gbox_cnt_o  = cnt_q;
    assign bus.idle_ins_o  = idle_q;

endmodule

// File: tb/tb_tx_gearbox66.sv
// tb/tb_tx_gearbox66.sv - self-checking bench for tx_gearbox66 (default build or TX_IDLE_INSERT_EN)
module tb_tx_gearbox66;
    import tx_gearbox66_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tx_gearbox66_if bus();

    tx_gearbox66 dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_pass = 0;
    int n_tot  = 0;

    // Reference: the transmitted stream is a plain FIFO of bits.
    bit          mq[$];
    block66_t    sb[$];
    bit          rxb[$];
    int          wcount;
    logic [31:0] m_last;
    logic [5:0]  m_cnt;
    int          n_acc;

    typedef struct {
        bit          v;
        logic [1:0]  h;
        logic [63:0] d;
        bit          rdy;
        bit          dv;
        logic [31:0] w;
        logic [5:0]  c;
        bit          idl;
    } vec_t;

    vec_t tv[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic void push_block(input logic [65:0] b);
        for (int i = 65; i >= 0; i--) mq.push_back(b[i]);
        sb.push_back(block66_t'(b));
    endfunction

    task automatic model_reset();
        mq.delete();
        sb.delete();
        rxb.delete();
        wcount = 0;
        m_last = '0;
        m_cnt  = '0;
        n_acc  = 0;
    endtask

    task automatic do_reset();
        bus.valid_i = 1'b0;
        bus.hdr_i   = 2'b00;
        bus.data_i  = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic cycle(input bit v, input logic [1:0] h, input logic [63:0] d);
        bit          m_rdy;
        bit          idl;
        bit          m_dv;
        logic [31:0] w;
        bus.valid_i = v;
        bus.hdr_i   = h;
        bus.data_i  = d;
        m_rdy = (mq.size() < 32);
        chk("ready", bus.ready_o, m_rdy);
        idl = 1'b0;
        if (v && m_rdy) begin
            push_block({h, d});
            n_acc++;
        end
`ifdef TX_IDLE_INSERT_EN
        else if (!v && m_rdy) begin
            push_block(idle_block());
            idl = 1'b1;
        end
`endif
        m_dv = 1'b0;
        if (mq.size() >= 32) begin
            w = '0;
            for (int i = 0; i < 32; i++) w = {w[30:0], mq.pop_front()};
            m_last = w;
            m_dv   = 1'b1;
            m_cnt  = 6'(wcount % c_FRAME_WORDS);
            wcount++;
        end
        @(posedge clk);
        #1;
        chk("dv", bus.gbox_dv_o, m_dv);
        chk("data", bus.gbox_data_o, m_last);
        chk("cnt", bus.gbox_cnt_o, m_cnt);
        chk("idle_ins", bus.idle_ins_o, idl);
        if (bus.gbox_dv_o === 1'b1)
            for (int i = 31; i >= 0; i--) rxb.push_back(bus.gbox_data_o[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int          rdy_cnt[3];
        int          acc_win[3];
        int          wraps;
        int          hdr_ok;
        logic [5:0]  prev_cnt;
        int          nblk;
        int          nmis;
        int          k;
        int          nlock;
        int          found;
        int          bad;
        logic [65:0] blkv;
        logic [63:0] dd;

        bus.valid_i = 1'b0;
        bus.hdr_i   = 2'b00;
        bus.data_i  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", bus.gbox_data_o, 32'h0);
        chk("rst_dv", bus.gbox_dv_o, 1'b0);
        chk("rst_cnt", bus.gbox_cnt_o, 6'd0);
        chk("rst_idle", bus.idle_ins_o, 1'b0);
        chk("rst_ready", bus.ready_o, 1'b0);

        // Single block then starve
        tv[0] = '{1'b1, 2'b10, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b1, 32'h8048_D159, 6'd0, 1'b0};
        tv[1] = '{1'b0, 2'b00, 64'h0,                   1'b0, 1'b1, 32'hE26A_F37B, 6'd1, 1'b0};
`ifdef TX_IDLE_INSERT_EN
        tv[2] = '{1'b0, 2'b00, 64'h0,                   1'b1, 1'b1, 32'hE780_0000, 6'd2, 1'b1};
        tv[3] = '{1'b0, 2'b00, 64'h0,                   1'b0, 1'b1, 32'h0000_0000, 6'd3, 1'b0};
        tv[4] = '{1'b1, 2'b01, 64'h0,                   1'b1, 1'b1, 32'h0400_0000, 6'd4, 1'b0};
`else
        tv[2] = '{1'b0, 2'b00, 64'h0,                   1'b1, 1'b0, 32'hE26A_F37B, 6'd1, 1'b0};
        tv[3] = '{1'b0, 2'b00, 64'h0,                   1'b1, 1'b0, 32'hE26A_F37B, 6'd1, 1'b0};
        tv[4] = '{1'b1, 2'b01, 64'h0,                   1'b1, 1'b1, 32'hD000_0000, 6'd2, 1'b0};
`endif
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.valid_i = tv[i].v;
            bus.hdr_i   = tv[i].h;
            bus.data_i  = tv[i].d;
            chk($sformatf("vec%0d_ready", i), bus.ready_o, tv[i].rdy);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_dv", i), bus.gbox_dv_o, tv[i].dv);
            chk($sformatf("vec%0d_data", i), bus.gbox_data_o, tv[i].w);
            chk($sformatf("vec%0d_cnt", i), bus.gbox_cnt_o, tv[i].c);
            chk($sformatf("vec%0d_idle", i), bus.idle_ins_o, tv[i].idl);
        end

        // Steady state, valid held high
        do_reset();
        wraps    = 0;
        hdr_ok   = 0;
        prev_cnt = '0;
        for (int w = 0; w < 3; w++) begin
            rdy_cnt[w] = 0;
            acc_win[w] = 0;
        end
        for (int i = 0; i < 99; i++) begin
            if (bus.ready_o === 1'b1) rdy_cnt[i / 33]++;
            k = n_acc;
            cycle(1'b1, c_DATA_HEADER, 64'hFFFF_FFFF_FFFF_FFFF);
            acc_win[i / 33] += n_acc - k;
            if (i == 0) chk("first_word", bus.gbox_data_o, 32'h7FFF_FFFF);
            if (i > 0 && prev_cnt == 6'd32 && bus.gbox_cnt_o == 6'd0) wraps++;
            if (bus.gbox_cnt_o == 6'd0 && bus.gbox_data_o[31:30] == c_DATA_HEADER) hdr_ok++;
            prev_cnt = bus.gbox_cnt_o;
        end
        for (int w = 0; w < 3; w++) begin
            chk($sformatf("accepts_win%0d", w), acc_win[w], 16);
            chk($sformatf("ready_high_win%0d", w), rdy_cnt[w], 16);
        end
        chk("cnt_wraps", wraps, 2);
        chk("cnt0_header_words", hdr_ok, 3);

        // Random valid, random headers/payloads, receive-side reconstruction
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            dd = {$urandom, $urandom};
            cycle(($urandom % 2) == 1, (($urandom % 2) == 1) ? c_CMD_HEADER : c_DATA_HEADER, dd);
        end
        nblk = rxb.size() / c_BLOCK_W;
        nmis = 0;
        for (int b = 0; b < nblk; b++) begin
            for (int i = 0; i < 66; i++) blkv[65 - i] = rxb[b * 66 + i];
            if (b >= sb.size() || blkv !== 66'(sb[b])) nmis++;
        end
        chk("rx_payload_mismatches", nmis, 0);
        chk("rx_blocks_all_delivered", (sb.size() - nblk) <= 1, 1'b1);
        chk("rx_enough_blocks", nblk > 200, 1'b1);

        k     = $urandom_range(1, 65);
        nlock = 0;
        found = -1;
        for (int o = 0; o < 66; o++) begin
            bad = 0;
            for (int n = 0; n < 40; n++)
                if (rxb[k + o + 66 * n] == rxb[k + o + 66 * n + 1]) bad++;
            if (bad == 0) begin
                nlock++;
                found = o;
            end
        end
        chk("lock_unique", nlock, 1);
        chk("lock_offset", found, 66 - k);
        bad = 0;
        if (found >= 0)
            for (int p = k + found; p + 1 < rxb.size(); p += 66)
                if (rxb[p] == rxb[p + 1]) bad++;
        chk("lock_stable", bad, 0);

        // Asynchronous reset mid-period at F = 36
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, c_DATA_HEADER, {$urandom, $urandom});
        bus.valid_i = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("async_data", bus.gbox_data_o, 32'h0);
        chk("async_dv", bus.gbox_dv_o, 1'b0);
        chk("async_cnt", bus.gbox_cnt_o, 6'd0);
        chk("async_idle", bus.idle_ins_o, 1'b0);
        chk("async_ready", bus.ready_o, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        dd = {$urandom, $urandom};
        cycle(1'b1, c_CMD_HEADER, dd);
        chk("post_reset_word", bus.gbox_data_o, {c_CMD_HEADER, dd[63:34]});
        cycle(1'b0, 2'b00, 64'h0);
        cycle(1'b1, c_DATA_HEADER, {$urandom, $urandom});

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
